sram_1rw_arbiter: RTL and testbench
===================================

# sram_1rw_arbiter

Controller that shares one 64x24 single-port SRAM macro (1RW port, one-cycle registered read) between an independent read requester and write requester. It optionally zero-fills the array after reset and arbitrates per cycle, giving writes priority with a bounded read-starvation guarantee. It sits between predictor/metadata update logic and the SRAM macro, and owns every macro control pin.

## Interface
- ADDR_W, 6, SRAM address width
- DATA_W, 24, SRAM data width
- DEPTH, 64, number of entries; equals 2**ADDR_W
- STARVE_LIMIT, 3, maximum consecutive cycles a pending read may lose to a write; range 1..15

Ports:
- clock  in  1  rising-edge clock for all state
- reset_n  in  1  asynchronous, active-low reset
- rd_valid  in  1  read request pending
- rd_ready  out  1  read accepted this cycle
- rd_addr  in  ADDR_W  read address
- resp_valid  out  1  read data valid; no backpressure
- resp_data  out  DATA_W  read data
- wr_valid  in  1  write request pending
- wr_ready  out  1  write accepted this cycle
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- init_done  out  1  array initialised; requests may be granted
- sram_en, sram_wmode  out  1 each  macro enable / write mode
- sram_wmask  out  1  macro write mask
- sram_addr  out  ADDR_W  macro address
- sram_wdata  out  DATA_W  macro write data
- sram_rdata  in  DATA_W  macro read data, valid the cycle after a read enable

## Operation
- States: INIT, RUN. Reset enters INIT (or RUN without the macro, see Configuration).
- INIT: init_cnt runs 0..DEPTH-1, one entry per cycle. Outputs: sram_en=1, sram_wmode=1, sram_wmask=1, sram_addr=init_cnt, sram_wdata=0. rd_ready=wr_ready=0. After the write to DEPTH-1, go to RUN.
- RUN: init_done=1. Per-cycle grant, combinational from valids and starve_cnt:
  - Only wr_valid: grant write.
  - Only rd_valid: grant read.
  - Both: grant the read if starve_cnt==STARVE_LIMIT; otherwise grant the write.
- Write grant: wr_ready=1, sram_en=1, sram_wmode=1, sram_wmask=1, sram_addr=wr_addr, sram_wdata=wr_data.
- Read grant: rd_ready=1, sram_en=1, sram_wmode=0, sram_addr=rd_addr.
- No grant: sram_en=0. sram_addr and sram_wdata hold 0.
- starve_cnt (4 bits):
  - Increments when both valids are high and the write wins.
  - Clears when a read is granted.
  - Holds otherwise.
  - Never exceeds STARVE_LIMIT.
- resp_valid is a register set on the cycle after a read grant. resp_data = sram_rdata when resp_valid=1, else 0.
- A write and a read never share a cycle, so a read granted after a write to the same address returns the new data.

## Timing
- Reset values: rd_ready=0, wr_ready=0, resp_valid=0, resp_data=0, sram_en=0, sram_wmode=0, sram_wmask=0, sram_addr=0, sram_wdata=0, starve_cnt=0, init_cnt=0.
- init_done=0 in INIT builds; init_done=1 otherwise.
- INIT occupies exactly DEPTH cycles after reset deassertion. init_done rises in cycle DEPTH+1, the first RUN cycle, and requests can be granted that cycle.
- Read latency: grant in cycle N, then resp_valid=1 with data in cycle N+1. Back-to-back reads give one response per cycle.
- The requester holds address/data stable while valid && !ready. The ready signals never depend on ready.
- Reset asserted mid-INIT or mid-RUN clears all state immediately. A pending response is dropped and INIT restarts from entry 0.
- Worst-case read wait under continuous writes: STARVE_LIMIT cycles, then granted.

## Configuration
- SRAM_ARB_INIT_EN defined: INIT state and init_cnt present. The zero-fill runs after every reset.
- Undefined: reset enters RUN directly. init_done is constant 1 and no zero-fill is performed. Array contents after reset are undefined.

## Test plan
- Init (macro defined): release reset, then 64 cycles of writes to addr 0..63 with data 0, rd_ready=0 throughout; init_done=1 at cycle 65. Read addr 63 -> resp_data=0x000000.
- Write then read: write addr 5 = 0xABCDEF in cycle N, read addr 5 in cycle N+1 -> resp_valid=1 with 0xABCDEF in cycle N+2.
- Starvation: rd_valid and wr_valid held high with STARVE_LIMIT=3 -> grants W,W,W,R,W,W,W,R…; the read at addr 10 is granted on the 4th cycle.
- Back-to-back reads addr 1,2,3 after writing 0x111,0x222,0x333 -> three consecutive resp_valid cycles carrying 0x111,0x222,0x333.
- Reset mid-op: assert reset_n=0 in the cycle after a read grant -> resp_valid=0 and sram_en=0 immediately. After release, INIT restarts at addr 0.
- Macro undefined: release reset -> init_done=1, and a write granted in the first cycle.

Source files
------------

// File: rtl/sram_1rw_arbiter.sv
// Shares one 1RW SRAM macro between a read and a write requester: writes win, reads wait at most STARVE_LIMIT cycles.
// Define SRAM_ARB_INIT_EN to zero-fill the array after every reset before granting requests.
module sram_1rw_arbiter #(
   parameter int ADDR_W       = 6,
   parameter int DATA_W       = 24,
   parameter int DEPTH        = 64,
   parameter int STARVE_LIMIT = 3
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              rd_valid,
   output logic              rd_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              init_done,
   output logic              sram_en,
   output logic              sram_wmode,
   output logic              sram_wmask,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata
);

   typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   state_t            state_r;
   logic [3:0]        starve_cnt_r, starve_next_s;
   logic              resp_valid_r;
   logic              rd_grant_s, wr_grant_s;
   logic              en_s, wmode_s, wmask_s;
   logic [ADDR_W-1:0] addr_s;
   logic [DATA_W-1:0] wdata_s;

`ifdef SRAM_ARB_INIT_EN
   logic [ADDR_W-1:0] init_cnt_r, init_cnt_next_s;
   state_t            state_next_s;

   // Zero-fill walk: one entry per cycle, then hand over to RUN
   always_comb begin
      state_next_s    = state_r;
      init_cnt_next_s = init_cnt_r;
      case (state_r)
         ST_INIT: begin
            init_cnt_next_s = init_cnt_r + ADDR_W'(1);
            if (init_cnt_r == ADDR_W'(DEPTH - 1)) begin
               state_next_s = ST_RUN;
            end else begin
               state_next_s = ST_INIT;
            end
         end
         ST_RUN:  state_next_s = ST_RUN;
         default: state_next_s = ST_INIT;
      endcase
   end

   // State and fill counter registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= ST_INIT;
         init_cnt_r <= '0;
      end else begin
         state_r    <= state_next_s;
         init_cnt_r <= init_cnt_next_s;
      end
   end

   assign init_done = (state_r == ST_RUN);
`else
   assign state_r   = ST_RUN;
   assign init_done = 1'b1;
`endif

   // Per-cycle grant and macro pin drive
   always_comb begin
      rd_grant_s    = 1'b0;
      wr_grant_s    = 1'b0;
      en_s          = 1'b0;
      wmode_s       = 1'b0;
      wmask_s       = 1'b0;
      addr_s        = '0;
      wdata_s       = '0;
      starve_next_s = starve_cnt_r;
      case (state_r)
         ST_INIT: begin
`ifdef SRAM_ARB_INIT_EN
            en_s    = 1'b1;
            wmode_s = 1'b1;
            wmask_s = 1'b1;
            addr_s  = init_cnt_r;
`endif
         end
         ST_RUN: begin
            if (rd_valid && wr_valid) begin
               if (starve_cnt_r == STARVE_MAX) begin
                  rd_grant_s    = 1'b1;
                  starve_next_s = 4'd0;
               end else begin
                  wr_grant_s    = 1'b1;
                  starve_next_s = starve_cnt_r + 4'd1;
               end
            end else if (wr_valid) begin
               wr_grant_s = 1'b1;
            end else if (rd_valid) begin
               rd_grant_s    = 1'b1;
               starve_next_s = 4'd0;
            end else begin
               starve_next_s = starve_cnt_r;
            end
            if (wr_grant_s) begin
               en_s    = 1'b1;
               wmode_s = 1'b1;
               wmask_s = 1'b1;
               addr_s  = wr_addr;
               wdata_s = wr_data;
            end else if (rd_grant_s) begin
               en_s   = 1'b1;
               addr_s = rd_addr;
            end else begin
               en_s = 1'b0;
            end
         end
         default: en_s = 1'b0;
      endcase
   end

   // Starvation counter and read-response valid
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         starve_cnt_r <= 4'd0;
         resp_valid_r <= 1'b0;
      end else begin
         starve_cnt_r <= starve_next_s;
         resp_valid_r <= rd_grant_s;
      end
   end

   // Reset forces every macro pin and handshake low at once, even while the FSM sits in RUN
   assign rd_ready   = reset_n & rd_grant_s;
   assign wr_ready   = reset_n & wr_grant_s;
   assign sram_en    = reset_n & en_s;
   assign sram_wmode = reset_n & wmode_s;
   assign sram_wmask = reset_n & wmask_s;
   assign sram_addr  = reset_n ? addr_s : '0;
   assign sram_wdata = reset_n ? wdata_s : '0;
   assign resp_valid = resp_valid_r;
   assign resp_data  = resp_valid_r ? sram_rdata : '0;

endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// Randomised scoreboard bench for sram_1rw_arbiter with a behavioural SRAM macro and reference model.
`timescale 1ns/1ps
module tb_sram_1rw_arbiter;
   localparam int ADDR_W = 6, DATA_W = 24, DEPTH = 64, LIMIT = 3;
`ifdef SRAM_ARB_INIT_EN
   localparam bit INIT_BUILD = 1'b1;
`else
   localparam bit INIT_BUILD = 1'b0;
`endif

   logic clock = 1'b0, reset_n = 1'b0;
   logic rd_valid, rd_ready, resp_valid, wr_valid, wr_ready, init_done;
   logic sram_en, sram_wmode, sram_wmask;
   logic [ADDR_W-1:0] rd_addr, wr_addr, sram_addr;
   logic [DATA_W-1:0] resp_data, wr_data, sram_wdata, sram_rdata;

   always #5 clock = ~clock;

   sram_1rw_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clock(clock), .reset_n(reset_n),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
      .resp_valid(resp_valid), .resp_data(resp_data),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .init_done(init_done), .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_wmask(sram_wmask),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata));

   // Behavioural single-port macro with one-cycle registered read
   logic [DATA_W-1:0] mem [DEPTH];
   always @(posedge clock) begin
      if (sram_en) begin
         if (sram_wmode) begin
            if (sram_wmask) mem[sram_addr] <= sram_wdata;
         end else begin
            sram_rdata <= mem[sram_addr];
         end
      end
   end

   int checks = 0, errors = 0, cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference model state
   typedef struct {int due; logic [DATA_W-1:0] data; bit known;} resp_t;
   resp_t             sb[$];
   logic [DATA_W-1:0] ref_mem [DEPTH];
   bit                known [DEPTH];
   int                lost, icnt;
   bit                in_init, m_rd_acc, m_wr_acc;

   // Grant / pin checker: predicts each cycle's arbitration and queues expected read data
   always @(negedge clock) begin
      bit gr, gw;
      resp_t e;
      if (!reset_n) begin
         chk("rst_rd_ready", 32'(rd_ready), 32'd0);
         chk("rst_wr_ready", 32'(wr_ready), 32'd0);
         chk("rst_resp_valid", 32'(resp_valid), 32'd0);
         chk("rst_resp_data", 32'(resp_data), 32'd0);
         chk("rst_sram_en", 32'(sram_en), 32'd0);
         chk("rst_wmode", 32'(sram_wmode), 32'd0);
         chk("rst_wmask", 32'(sram_wmask), 32'd0);
         chk("rst_addr", 32'(sram_addr), 32'd0);
         chk("rst_wdata", 32'(sram_wdata), 32'd0);
         chk("rst_init_done", 32'(init_done), 32'(!INIT_BUILD));
         lost = 0; icnt = 0; in_init = INIT_BUILD; m_rd_acc = 1'b0; m_wr_acc = 1'b0;
         for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
      end else if (in_init) begin
         chk("init_done_low", 32'(init_done), 32'd0);
         chk("init_rd_ready", 32'(rd_ready), 32'd0);
         chk("init_wr_ready", 32'(wr_ready), 32'd0);
         chk("init_en", 32'({sram_en, sram_wmode, sram_wmask}), 32'd7);
         chk("init_addr", 32'(sram_addr), 32'(icnt));
         chk("init_wdata", 32'(sram_wdata), 32'd0);
         ref_mem[icnt] = '0; known[icnt] = 1'b1;
         icnt++;
         if (icnt == DEPTH) in_init = 1'b0;
         m_rd_acc = 1'b0; m_wr_acc = 1'b0;
      end else begin
         gr = 1'b0; gw = 1'b0;
         if (rd_valid && wr_valid) begin
            if (lost >= LIMIT) gr = 1'b1; else gw = 1'b1;
         end else begin
            gr = rd_valid; gw = wr_valid;
         end
         if (rd_valid && wr_valid && gw) lost++;
         else if (gr) lost = 0;
         chk("init_done", 32'(init_done), 32'd1);
         chk("rd_ready", 32'(rd_ready), 32'(gr));
         chk("wr_ready", 32'(wr_ready), 32'(gw));
         chk("sram_en", 32'(sram_en), 32'(gr | gw));
         if (gw) begin
            chk("wr_mode", 32'({sram_wmode, sram_wmask}), 32'd3);
            chk("wr_addr", 32'(sram_addr), 32'(wr_addr));
            chk("wr_wdata", 32'(sram_wdata), 32'(wr_data));
            ref_mem[wr_addr] = wr_data; known[wr_addr] = 1'b1;
         end else if (gr) begin
            chk("rd_mode", 32'(sram_wmode), 32'd0);
            chk("rd_addr", 32'(sram_addr), 32'(rd_addr));
            e.due = cyc + 1; e.data = ref_mem[rd_addr]; e.known = known[rd_addr];
            sb.push_back(e);
         end else begin
            chk("idle_addr", 32'(sram_addr), 32'd0);
            chk("idle_wdata", 32'(sram_wdata), 32'd0);
         end
         m_rd_acc = gr; m_wr_acc = gw;
      end
   end

   // Response monitor: pops the scoreboard whenever a response is due
   always @(negedge clock) begin
      resp_t e;
      if (!reset_n) begin
         sb.delete();
      end else if (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         chk("resp_valid", 32'(resp_valid), 32'd1);
         if (e.known) chk("resp_data", 32'(resp_data), 32'(e.data));
      end else begin
         chk("resp_valid_idle", 32'(resp_valid), 32'd0);
         chk("resp_data_idle", 32'(resp_data), 32'd0);
      end
   end

   task automatic drive(input bit rv, input logic [ADDR_W-1:0] ra, input bit wv,
                        input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
      rd_valid = rv; rd_addr = ra; wr_valid = wv; wr_addr = wa; wr_data = wd;
      @(posedge clock); #1;
   endtask

   initial begin
      logic [7:0] pat;
      rd_valid = 1'b0; wr_valid = 1'b0; rd_addr = '0; wr_addr = '0; wr_data = '0;
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
      if (INIT_BUILD) repeat (DEPTH) drive(1'b1, 6'd63, 1'b1, 6'd7, 24'h123456);
      drive(1'b1, 6'd63, 1'b1, 6'd7, 24'h123456);
      drive(1'b1, 6'd63, 1'b0, 6'd0, 24'h0);
      for (int i = 0; i < DEPTH; i++) drive(1'b0, 6'd0, 1'b1, 6'(i), 24'($urandom));

      // write then read the same address on the next cycle
      drive(1'b0, 6'd0, 1'b1, 6'd5, 24'hABCDEF);
      drive(1'b1, 6'd5, 1'b0, 6'd0, 24'h0);
      rd_valid = 1'b0;
      @(negedge clock);
      chk("wr_then_rd_data", 32'(resp_data), 32'h00ABCDEF);
      @(posedge clock); #1;

      // back-to-back reads
      drive(1'b0, 6'd0, 1'b1, 6'd1, 24'h000111);
      drive(1'b0, 6'd0, 1'b1, 6'd2, 24'h000222);
      drive(1'b0, 6'd0, 1'b1, 6'd3, 24'h000333);
      drive(1'b1, 6'd1, 1'b0, 6'd0, 24'h0);
      drive(1'b1, 6'd2, 1'b0, 6'd0, 24'h0);
      drive(1'b1, 6'd3, 1'b0, 6'd0, 24'h0);
      rd_valid = 1'b0;
      @(negedge clock);
      chk("b2b_third_data", 32'(resp_data), 32'h00000333);
      @(posedge clock); #1;

      // continuous contention: W,W,W,R,W,W,W,R
      pat = 8'b1000_1000;
      rd_valid = 1'b1; rd_addr = 6'd10; wr_valid = 1'b1; wr_addr = 6'd20; wr_data = 24'h5A5A5A;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         chk("starve_pattern", 32'(rd_ready), 32'(pat[k]));
         @(posedge clock); #1;
      end

      // randomised traffic honouring hold-until-accepted
      for (int n = 0; n < 400; n++) begin
         if (!(rd_valid && !m_rd_acc)) begin
            rd_valid = 1'($urandom_range(0, 1)); rd_addr = 6'($urandom);
         end
         if (!(wr_valid && !m_wr_acc)) begin
            wr_valid = ($urandom_range(0, 9) < 6); wr_addr = 6'($urandom); wr_data = 24'($urandom);
         end
         @(posedge clock); #1;
      end

      // reset in the cycle after a read grant
      if (!(rd_valid && !m_rd_acc)) rd_addr = 6'd9;
      drive(1'b1, rd_addr, 1'b0, 6'd0, 24'h0);
      while (!m_rd_acc) drive(1'b1, rd_addr, 1'b0, 6'd0, 24'h0);
      rd_valid = 1'b0;
      reset_n = 1'b0;
      @(negedge clock);
      chk("midreset_resp_valid", 32'(resp_valid), 32'd0);
      chk("midreset_sram_en", 32'(sram_en), 32'd0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      wr_valid = 1'b1; wr_addr = 6'd33; wr_data = 24'h0F0F0F;
      @(negedge clock);
      chk("first_cycle_wr_ready", 32'(wr_ready), 32'(!INIT_BUILD));
      chk("first_cycle_addr", 32'(sram_addr), INIT_BUILD ? 32'd0 : 32'd33);
      @(posedge clock); #1;
      if (INIT_BUILD) repeat (DEPTH + 2) drive(1'b0, 6'd0, 1'b1, 6'd33, 24'h0F0F0F);
      drive(1'b0, 6'd0, 1'b0, 6'd0, 24'h0);
      drive(1'b1, 6'd33, 1'b0, 6'd0, 24'h0);
      drive(1'b0, 6'd0, 1'b0, 6'd0, 24'h0);
      repeat (3) @(posedge clock);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
